// File: rtl/spi_param_pkg.sv
// Shared definitions for the SPI parameter register bank.
//   WORD_BASE : first address of the 16-bit word register window
//   CLR_ADRS  : address that triggers a bank clear
//   CLR_KEY   : data byte that must accompany CLR_ADRS for the clear to execute
//   dec_e     : classification of one received frame
//   sat_inc8  : 8-bit increment that sticks at 8'hFF
package spi_param_pkg;

  localparam logic [7:0] WORD_BASE = 8'h80;
  localparam logic [7:0] CLR_ADRS  = 8'hFF;
  localparam logic [7:0] CLR_KEY   = 8'hA5;

  typedef enum logic [2:0] {
    DEC_BYTE = 3'd0,  // byte register write
    DEC_WHI  = 3'd1,  // word high byte, goes to staging
    DEC_WLO  = 3'd2,  // word low byte, commits a staged word
    DEC_CLR  = 3'd3,  // keyed bank clear
    DEC_ERR  = 3'd4   // anything else
  } dec_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

endpackage

// File: rtl/spi_frame_decode.sv
// Combinational classifier for one SPI frame.
// Ports:
//   adrs     in  8  frame address
//   data     in  8  frame data (only consulted for the clear key)
//   dec_kind out    decode result (dec_e)
//   dec_idx  out 8  byte index for DEC_BYTE, word index k for DEC_WHI/DEC_WLO,
//                   zero otherwise
module spi_frame_decode
  import spi_param_pkg::*;
#(
  parameter int NUM_BYTES = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic [7:0] adrs,
  input  logic [7:0] data,
  output dec_e       dec_kind,
  output logic [7:0] dec_idx
);

  // Window limits are held at 9 bits so that 0x80 + 2*63 and a full 128-entry
  // byte map compare cleanly against the 8-bit address.
  localparam logic [8:0] BYTE_END  = 9'(NUM_BYTES);
  localparam logic [8:0] WORD_LO   = {1'b0, WORD_BASE};
  localparam logic [8:0] WORD_END  = WORD_LO + 9'(2 * NUM_WORDS);

  logic [8:0] adrs_x;
  logic [7:0] word_off;

  always_comb begin
    adrs_x   = {1'b0, adrs};
    word_off = adrs - WORD_BASE;
    dec_kind = DEC_ERR;
    dec_idx  = 8'h00;
    if (adrs_x < BYTE_END) begin
      dec_kind = DEC_BYTE;
      dec_idx  = adrs;
    end else if ((adrs_x >= WORD_LO) && (adrs_x < WORD_END)) begin
      // Even offset = high byte, odd offset = low byte of word k = offset/2.
      dec_kind = word_off[0] ? DEC_WLO : DEC_WHI;
      dec_idx  = {1'b0, word_off[7:1]};
    end else if ((adrs == CLR_ADRS) && (data == CLR_KEY)) begin
      dec_kind = DEC_CLR;
    end
  end

endmodule

// File: rtl/spi_param_regs.sv
// Synth parameter register bank fed by decoded SPI frames.
// Holds NUM_BYTES byte registers and NUM_WORDS 16-bit word registers (written
// as a high/low pair through a one-entry staging register), registered read
// ports, an update strobe per committed write or clear, and a saturating count
// of rejected frames.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   adrs, data      frame address/data from the SPI receiver
//   rx_valid        frame-valid level
//   rd_byte_sel     byte read select  -> rd_byte_data (1-cycle latency)
//   rd_word_sel     word read select  -> rd_word_data (1-cycle latency)
//   upd_valid       one-cycle strobe per committed write or clear
//   upd_is_word     1 = word commit, 0 = byte write / clear
//   upd_index       byte index, word index, or 0xFF for a clear
//   upd_value       written value (bytes zero-extended, 0 for a clear)
//   clr_done        one-cycle strobe when a bank clear executes
//   err_cnt         saturating rejected-frame count
//
// Handshake: rx_valid is a level with no back-pressure. A frame is taken on the
// cycle rx_valid rises (rx_valid & ~rx_valid_d); adrs/data are sampled in that
// cycle only, and holding rx_valid high longer never produces a second accept.
// Reset clears the delayed copy, so rx_valid already high when reset drops is
// taken as a fresh frame.
module spi_param_regs
  import spi_param_pkg::*;
#(
  parameter int NUM_BYTES = 32,
  parameter int NUM_WORDS = 8,
  localparam int BSEL_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1,
  localparam int WSEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        adrs,
  input  logic [7:0]        data,
  input  logic              rx_valid,
  input  logic [BSEL_W-1:0] rd_byte_sel,
  output logic [7:0]        rd_byte_data,
  input  logic [WSEL_W-1:0] rd_word_sel,
  output logic [15:0]       rd_word_data,
  output logic              upd_valid,
  output logic              upd_is_word,
  output logic [7:0]        upd_index,
  output logic [15:0]       upd_value,
  output logic              clr_done,
  output logic [7:0]        err_cnt
);

  if ((NUM_BYTES < 1) || (NUM_BYTES > 128)) begin : g_bad_num_bytes
    $error("spi_param_regs: NUM_BYTES must be 1..128");
  end
  if ((NUM_WORDS < 1) || (NUM_WORDS > 63)) begin : g_bad_num_words
    $error("spi_param_regs: NUM_WORDS must be 1..63");
  end

  // ---------------------------------------------------------------------------
  // Frame decode
  // ---------------------------------------------------------------------------
  dec_e       dec_kind;
  logic [7:0] dec_idx;

  spi_frame_decode #(
    .NUM_BYTES (NUM_BYTES),
    .NUM_WORDS (NUM_WORDS)
  ) u_decode (
    .adrs     (adrs),
    .data     (data),
    .dec_kind (dec_kind),
    .dec_idx  (dec_idx)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        rx_valid_d_q,  rx_valid_d_d;
  logic [7:0]  byte_q [NUM_BYTES];
  logic [7:0]  byte_d [NUM_BYTES];
  logic [15:0] word_q [NUM_WORDS];
  logic [15:0] word_d [NUM_WORDS];
  logic [7:0]  stage_hi_q,    stage_hi_d;
  logic [7:0]  stage_idx_q,   stage_idx_d;
  logic        stage_vld_q,   stage_vld_d;
  logic        upd_valid_q,   upd_valid_d;
  logic        upd_is_word_q, upd_is_word_d;
  logic [7:0]  upd_index_q,   upd_index_d;
  logic [15:0] upd_value_q,   upd_value_d;
  logic        clr_done_q,    clr_done_d;
  logic [7:0]  err_cnt_q,     err_cnt_d;
  logic [7:0]  rd_byte_data_q, rd_byte_data_d;
  logic [15:0] rd_word_data_q, rd_word_data_d;

  logic accept;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    accept        = rx_valid & ~rx_valid_d_q;
    rx_valid_d_d  = rx_valid;
    byte_d        = byte_q;
    word_d        = word_q;
    stage_hi_d    = stage_hi_q;
    stage_idx_d   = stage_idx_q;
    stage_vld_d   = stage_vld_q;
    upd_valid_d   = 1'b0;
    clr_done_d    = 1'b0;
    upd_is_word_d = upd_is_word_q;
    upd_index_d   = upd_index_q;
    upd_value_d   = upd_value_q;
    err_cnt_d     = err_cnt_q;

    if (accept) begin
      case (dec_kind)
        DEC_BYTE: begin
          for (int i = 0; i < NUM_BYTES; i++) begin
            if (dec_idx == 8'(i)) byte_d[i] = data;
          end
          upd_valid_d   = 1'b1;
          upd_is_word_d = 1'b0;
          upd_index_d   = dec_idx;
          upd_value_d   = {8'h00, data};
        end
        DEC_WHI: begin
          // A repeated high byte simply replaces whatever was staged.
          stage_hi_d  = data;
          stage_idx_d = dec_idx;
          stage_vld_d = 1'b1;
        end
        DEC_WLO: begin
          if (stage_vld_q && (stage_idx_q == dec_idx)) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (dec_idx == 8'(i)) word_d[i] = {stage_hi_q, data};
            end
            upd_valid_d   = 1'b1;
            upd_is_word_d = 1'b1;
            upd_index_d   = dec_idx;
            upd_value_d   = {stage_hi_q, data};
          end else begin
            err_cnt_d = sat_inc8(err_cnt_q);
          end
          // A low byte always consumes the staging, matched or not, so a
          // stale high byte can never pair with a later low byte.
          stage_vld_d = 1'b0;
        end
        DEC_CLR: begin
          for (int i = 0; i < NUM_BYTES; i++) byte_d[i] = 8'h00;
          for (int i = 0; i < NUM_WORDS; i++) word_d[i] = 16'h0000;
          stage_hi_d    = 8'h00;
          stage_idx_d   = 8'h00;
          stage_vld_d   = 1'b0;
          clr_done_d    = 1'b1;
          upd_valid_d   = 1'b1;
          upd_is_word_d = 1'b0;
          upd_index_d   = CLR_ADRS;
          upd_value_d   = 16'h0000;
        end
        default: begin
          err_cnt_d = sat_inc8(err_cnt_q);
        end
      endcase
    end

    // Read ports sample the current (pre-write) bank; selects beyond the
    // populated range fall through to zero.
    rd_byte_data_d = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (rd_byte_sel == BSEL_W'(i)) rd_byte_data_d = byte_q[i];
    end
    rd_word_data_d = 16'h0000;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (rd_word_sel == WSEL_W'(i)) rd_word_data_d = word_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_d_q <= 1'b0;
      for (int i = 0; i < NUM_BYTES; i++) byte_q[i] <= 8'h00;
      for (int i = 0; i < NUM_WORDS; i++) word_q[i] <= 16'h0000;
      stage_hi_q     <= 8'h00;
      stage_idx_q    <= 8'h00;
      stage_vld_q    <= 1'b0;
      upd_valid_q    <= 1'b0;
      upd_is_word_q  <= 1'b0;
      upd_index_q    <= 8'h00;
      upd_value_q    <= 16'h0000;
      clr_done_q     <= 1'b0;
      err_cnt_q      <= 8'h00;
      rd_byte_data_q <= 8'h00;
      rd_word_data_q <= 16'h0000;
    end else begin
      rx_valid_d_q   <= rx_valid_d_d;
      byte_q         <= byte_d;
      word_q         <= word_d;
      stage_hi_q     <= stage_hi_d;
      stage_idx_q    <= stage_idx_d;
      stage_vld_q    <= stage_vld_d;
      upd_valid_q    <= upd_valid_d;
      upd_is_word_q  <= upd_is_word_d;
      upd_index_q    <= upd_index_d;
      upd_value_q    <= upd_value_d;
      clr_done_q     <= clr_done_d;
      err_cnt_q      <= err_cnt_d;
      rd_byte_data_q <= rd_byte_data_d;
      rd_word_data_q <= rd_word_data_d;
    end
  end

  assign rd_byte_data = rd_byte_data_q;
  assign rd_word_data = rd_word_data_q;
  assign upd_valid    = upd_valid_q;
  assign upd_is_word  = upd_is_word_q;
  assign upd_index    = upd_index_q;
  assign upd_value    = upd_value_q;
  assign clr_done     = clr_done_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_spi_param_regs.sv
// Directed bench for spi_param_regs (NUM_BYTES = 32, NUM_WORDS = 6).
// Update strobes are scored against an expected queue filled by the driver
// before each frame that should commit; everything else is checked inline.
module tb_spi_param_regs;

  logic        clk;
  logic        reset;
  logic [7:0]  adrs;
  logic [7:0]  data;
  logic        rx_valid;
  logic [4:0]  rd_byte_sel;
  logic [7:0]  rd_byte_data;
  logic [2:0]  rd_word_sel;
  logic [15:0] rd_word_data;
  logic        upd_valid;
  logic        upd_is_word;
  logic [7:0]  upd_index;
  logic [15:0] upd_value;
  logic        clr_done;
  logic [7:0]  err_cnt;

  spi_param_regs #(
    .NUM_BYTES (32),
    .NUM_WORDS (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .adrs         (adrs),
    .data         (data),
    .rx_valid     (rx_valid),
    .rd_byte_sel  (rd_byte_sel),
    .rd_byte_data (rd_byte_data),
    .rd_word_sel  (rd_word_sel),
    .rd_word_data (rd_word_data),
    .upd_valid    (upd_valid),
    .upd_is_word  (upd_is_word),
    .upd_index    (upd_index),
    .upd_value    (upd_value),
    .clr_done     (clr_done),
    .err_cnt      (err_cnt)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checker and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  // {is_word, index[7:0], value[15:0]}
  logic [24:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  logic prev_upd = 1'b0;
  always @(negedge clk) begin
    if (!reset && upd_valid) begin
      check("upd_back2back", {31'b0, prev_upd}, 32'd0);
      if (exp_q.size() == 0)
        check("upd_unexpected", 32'(exp_q.size()), 32'd1);
      else
        check("upd_fields", {7'b0, upd_is_word, upd_index, upd_value},
              {7'b0, exp_q.pop_front()});
    end
    prev_upd = upd_valid;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise rx_valid for 'hold' cycles. Returns on the negedge where rx_valid
  // drops; every effect of the frame is visible at that point.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    adrs     = a;
    data     = d;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_upd(input logic w, input logic [7:0] idx, input logic [15:0] val);
    exp_q.push_back({w, idx, val});
  endtask

  task automatic read_byte(input string tag, input logic [4:0] sel, input logic [7:0] exp);
    @(negedge clk);
    rd_byte_sel = sel;
    @(negedge clk);
    check(tag, {24'b0, rd_byte_data}, {24'b0, exp});
  endtask

  task automatic read_word(input string tag, input logic [2:0] sel, input logic [15:0] exp);
    @(negedge clk);
    rd_word_sel = sel;
    @(negedge clk);
    check(tag, {16'b0, rd_word_data}, {16'b0, exp});
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    adrs        = 8'h00;
    data        = 8'h00;
    rx_valid    = 1'b0;
    rd_byte_sel = 5'd0;
    rd_word_sel = 3'd0;
    do_reset(3);

    // Reset state
    check("rst_rd_byte",  {24'b0, rd_byte_data}, 32'h0);
    check("rst_rd_word",  {16'b0, rd_word_data}, 32'h0);
    check("rst_upd",      {31'b0, upd_valid},    32'h0);
    check("rst_clr_done", {31'b0, clr_done},     32'h0);
    check("rst_err_cnt",  {24'b0, err_cnt},      32'h0);

    // Byte write with rx_valid held 3 cycles: one strobe only
    expect_upd(1'b0, 8'h05, 16'h003C);
    send_frame(8'h05, 8'h3C, 3);
    read_byte("byte5", 5'd5, 8'h3C);

    // Read-during-write: old value first, new value next cycle
    expect_upd(1'b0, 8'h09, 16'h005A);
    @(negedge clk);
    rd_byte_sel = 5'd9;
    adrs        = 8'h09;
    data        = 8'h5A;
    rx_valid    = 1'b1;
    @(negedge clk);
    check("rdw_old", {24'b0, rd_byte_data}, 32'h00);
    @(negedge clk);
    check("rdw_new", {24'b0, rd_byte_data}, 32'h5A);
    rx_valid = 1'b0;

    // Word pair: high byte stages silently, low byte commits word 1
    send_frame(8'h82, 8'h12, 2);
    check("whi_no_upd", {31'b0, upd_valid}, 32'h0);
    expect_upd(1'b1, 8'h01, 16'h1234);
    send_frame(8'h83, 8'h34, 1);
    read_word("word1", 3'd1, 16'h1234);
    check("pair_err_cnt", {24'b0, err_cnt}, 32'd0);

    // Mismatched pair, then a lone low byte
    send_frame(8'h82, 8'hAA, 1);
    send_frame(8'h85, 8'h55, 1);
    check("mismatch_err", {24'b0, err_cnt}, 32'd1);
    read_word("mismatch_w1", 3'd1, 16'h1234);
    read_word("mismatch_w2", 3'd2, 16'h0000);
    send_frame(8'h83, 8'h77, 1);
    check("lone_lo_err", {24'b0, err_cnt}, 32'd2);
    read_word("lone_lo_w1", 3'd1, 16'h1234);

    // Last word of a 6-word map, select past the end, address past the window
    send_frame(8'h8A, 8'hBE, 1);
    expect_upd(1'b1, 8'h05, 16'hBEEF);
    send_frame(8'h8B, 8'hEF, 1);
    read_word("word5", 3'd5, 16'hBEEF);
    read_word("word_sel6_oor", 3'd6, 16'h0000);
    send_frame(8'h8C, 8'h01, 1);
    check("word_window_err", {24'b0, err_cnt}, 32'd3);
    expect_upd(1'b0, 8'h1F, 16'h00EE);
    send_frame(8'h1F, 8'hEE, 2);
    read_byte("byte31", 5'd31, 8'hEE);

    // Keyed clear
    expect_upd(1'b0, 8'hFF, 16'h0000);
    send_frame(8'hFF, 8'hA5, 1);
    check("clr_done_pulse", {31'b0, clr_done}, 32'h1);
    check("clr_err_kept",   {24'b0, err_cnt},  32'd3);
    @(negedge clk);
    check("clr_done_low",   {31'b0, clr_done}, 32'h0);
    read_byte("clr_byte5",  5'd5,  8'h00);
    read_byte("clr_byte9",  5'd9,  8'h00);
    read_byte("clr_byte31", 5'd31, 8'h00);
    read_word("clr_word1",  3'd1,  16'h0000);
    read_word("clr_word5",  3'd5,  16'h0000);

    // Wrong key: error, no clear
    expect_upd(1'b0, 8'h03, 16'h0099);
    send_frame(8'h03, 8'h99, 1);
    send_frame(8'hFF, 8'h00, 1);
    check("badkey_err",     {24'b0, err_cnt},  32'd4);
    check("badkey_no_clr",  {31'b0, clr_done}, 32'h0);
    read_byte("badkey_byte3", 5'd3, 8'h99);

    // Saturation: 300 out-of-range byte writes (err_cnt starts at 4)
    for (int i = 0; i < 250; i++) send_frame(8'h40, 8'(i), 1);
    check("sat_fe", {24'b0, err_cnt}, 32'hFE);
    send_frame(8'h40, 8'h00, 1);
    check("sat_ff", {24'b0, err_cnt}, 32'hFF);
    for (int i = 0; i < 49; i++) send_frame(8'h40, 8'(i), 1);
    check("sat_hold", {24'b0, err_cnt}, 32'hFF);
    read_byte("sat_byte0", 5'd0, 8'h00);

    // Reset between high and low byte discards the staging
    do_reset(2);
    check("rst2_err_cnt", {24'b0, err_cnt}, 32'd0);
    send_frame(8'h80, 8'h11, 1);
    do_reset(2);
    send_frame(8'h81, 8'h22, 1);
    check("rst_lone_lo_err", {24'b0, err_cnt}, 32'd1);
    read_word("rst_word0", 3'd0, 16'h0000);

    // rx_valid already high when reset drops counts as a rising edge
    @(negedge clk);
    reset    = 1'b1;
    adrs     = 8'h07;
    data     = 8'h77;
    rx_valid = 1'b1;
    expect_upd(1'b0, 8'h07, 16'h0077);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_edge_upd", {31'b0, upd_valid}, 32'h1);
    @(negedge clk);
    rx_valid = 1'b0;
    read_byte("post_rst_byte7", 5'd7, 8'h77);

    repeat (3) @(negedge clk);
    check("upd_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_param_regs.md
Name: spi_param_regs

Overview:
Consumes the decoded SPI frames (8-bit address, 8-bit data, rx_valid level) produced by the SPI receiver stage. Maintains the synth parameter register bank:
- byte registers;
- 16-bit word registers, written as a high/low byte pair.

Provides registered read ports to the synth engine, emits one update strobe per committed write, and counts malformed accesses.

Parameters:
NUM_BYTES, 32, number of 8-bit byte registers; address map 0x00..NUM_BYTES-1; legal range 1..128.
NUM_WORDS, 8, number of 16-bit word registers; address map 0x80..0x80+2*NUM_WORDS-1; legal range 1..63.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
adrs  in  8  frame address from SPI receiver
data  in  8  frame data from SPI receiver
rx_valid  in  1  frame-valid level; may stay high for several clk cycles per frame
rd_byte_sel  in  clog2(NUM_BYTES)  byte register read select
rd_byte_data  out  8  selected byte register, registered
rd_word_sel  in  clog2(NUM_WORDS)  word register read select
rd_word_data  out  16  selected word register, registered
upd_valid  out  1  one-cycle pulse per committed write or clear
upd_is_word  out  1  1 = word commit, 0 = byte write; valid with upd_valid
upd_index  out  8  byte or word index written; valid with upd_valid
upd_value  out  16  written value; byte writes are zero-extended; valid with upd_valid
clr_done  out  1  one-cycle pulse when a bank clear executes
err_cnt  out  8  saturating count of rejected frames

Behaviour:
- Reset (sync, high): all registers, staging and rd_* outputs = 0; upd_valid = 0; clr_done = 0; err_cnt = 0; rx_valid_d = 0.
- Frame accept:
  - accept = rx_valid & ~rx_valid_d, where rx_valid_d is rx_valid delayed one clk.
  - Exactly one accept per rx_valid high period.
  - adrs/data are sampled in the accept cycle T.
  - rx_valid high on the first cycle after reset counts as an edge.
- Decode at T; all effects, including upd_* and err_cnt, are visible at T+1:
  - Byte write (adrs < NUM_BYTES): byte[adrs] <= data. upd_valid = 1, upd_is_word = 0, upd_index = adrs, upd_value = {8'h00, data}. Staging is unaffected.
  - Word high (adrs = 0x80+2k, k < NUM_WORDS): stage_hi <= data, stage_idx <= k, stage_vld <= 1. No upd pulse. A second high write overwrites the staging.
  - Word low (adrs = 0x81+2k, k < NUM_WORDS):
    - If stage_vld and stage_idx == k: word[k] <= {stage_hi, data}, stage_vld <= 0, upd_valid = 1, upd_is_word = 1, upd_index = k, upd_value = the word.
    - Otherwise: error, no write, stage_vld <= 0.
  - Clear (adrs = 0xFF, data = 0xA5): all byte and word registers and staging <= 0; clr_done = 1; upd_valid = 1, upd_is_word = 0, upd_index = 0xFF, upd_value = 0. err_cnt is kept.
  - Any other address, or 0xFF with data != 0xA5: error.
  - Error: err_cnt <= err_cnt + 1, saturating at 0xFF (no wrap). No register change except the stage_vld clear described for word low.
- Read ports:
  - rd_byte_data <= byte[rd_byte_sel] every cycle; rd_word_data <= word[rd_word_sel] every cycle. One-cycle latency.
  - Read-during-write returns the old value in the write cycle and the new value the following cycle.
  - Out-of-range select (non-power-of-two sizes) reads 0.
- upd_valid is never high on two consecutive cycles, because accept requires a low-to-high transition.
- Reset mid-sequence: staging is discarded; a subsequent lone low byte is an error.

Decomposition:
- Shared package spi_param_pkg:
  - WORD_BASE = 8'h80;
  - CLR_ADRS = 8'hFF;
  - CLR_KEY = 8'hA5;
  - enum for the decode result (DEC_BYTE, DEC_WHI, DEC_WLO, DEC_CLR, DEC_ERR).
- One sub-module, spi_frame_decode: purely combinational, mapping adrs/data and the parameters to the decode result plus index. The main module holds the edge detect, bank, staging, read ports and counters.

Test Plan:
- Reset, then a byte write: rx_valid high 3 cycles with adrs = 0x05, data = 0x3C -> exactly one upd_valid pulse; upd_index = 5, upd_value = 0x003C, upd_is_word = 0; rd_byte_sel = 5 yields 0x3C after 1 cycle.
- Word pair: 0x82 = 0x12, then 0x83 = 0x34 -> single upd_valid with upd_is_word = 1, upd_index = 1, upd_value = 0x1234; no pulse after the high byte.
- Mismatched pair: 0x82 = 0xAA, then 0x85 = 0x55 -> err_cnt = 1, word[1] and word[2] unchanged. A following lone 0x83 -> err_cnt = 2.
- Clear: fill bytes and words, then 0xFF = 0xA5 -> clr_done pulse, all reads 0, err_cnt retained. 0xFF = 0x00 -> err_cnt + 1, no clear.
- Saturation and range: 300 writes to address 0x40 (NUM_BYTES = 32) -> err_cnt = 0xFF, no upd pulses.
- Reset between high byte 0x80 = 0x11 and low byte 0x81 = 0x22 -> the low byte counts as an error, word[0] = 0.
